if_fetch_queue: RTL and testbench

//  Instruction-fetch stage between pc_unit and decode. Issues fetches for the current PC to

---
 rtl/if_fetch_queue.sv | 165 ++++++++++++++++
 tb/tb_if_fetch_queue.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Purpose  : Instruction-fetch queue between pc_unit and decode. Issues fetch
//            requests for the current PC, buffers in-order responses and
//            presents them to decode; discards wrong-path fetches on redirect.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_src,
  output logic        fetch_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_fault
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Queue storage
  logic [31:0]       ent_pc    [DEPTH];
  logic [31:0]       ent_instr [DEPTH];
  logic [DEPTH-1:0]  ent_filled;
  logic [DEPTH-1:0]  ent_fault;

  // Queue bookkeeping
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  pend;      // allocated entries still waiting for data
  logic [CNT_W-1:0]  drop_cnt;  // in-flight responses belonging to flushed fetches

  // Datapath / handshake terms
  logic [CNT_W:0]    occupancy;
  logic              aligned;
  logic              alloc_ok;
  logic              can_alloc;
  logic              req_fire;
  logic              fault_alloc;
  logic              accept;
  logic              head_filled;
  logic              pop;
  logic              rsp_drop;
  logic              rsp_fill;
  logic              rsp_err;
  logic              fill_found;
  logic [PTR_W-1:0]  fill_idx;

  // Modulo-DEPTH pointer advance; works for non-power-of-two depths too.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(n);
    if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  // Request side: a slot is reserved for every fetch in flight, including ones
  // that will be dropped, so a same-cycle pop never frees room early.
  always_comb begin
    occupancy      = {1'b0, count} + {1'b0, drop_cnt};
    aligned        = (pc[1:0] == 2'b00);
    alloc_ok       = (occupancy < (CNT_W+1)'(DEPTH));
    can_alloc      = !rst && !pc_src && alloc_ok;
    imem_req_valid = can_alloc && aligned;
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
    fault_alloc    = can_alloc && !aligned;
    accept         = req_fire || fault_alloc;
    fetch_stall    = rst || !(accept || pc_src);
  end

  // Response side: stale responses are consumed first, then fills go to the
  // oldest unfilled entry found by scanning from the head.
  always_comb begin
    rsp_drop   = imem_rsp_valid && (drop_cnt != '0);
    rsp_fill   = imem_rsp_valid && (drop_cnt == '0) && (pend != '0);
    rsp_err    = imem_rsp_valid && (drop_cnt == '0) && (pend == '0);
    fill_found = 1'b0;
    fill_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!fill_found && (CNT_W'(i) < count) && !ent_filled[ptr_add(rd_ptr, i)]) begin
        fill_found = 1'b1;
        fill_idx   = ptr_add(rd_ptr, i);
      end
    end
  end

  // Decode side: head entry presented only once its data is present.
  always_comb begin
    head_filled = (count != '0) && ent_filled[rd_ptr];
    id_valid    = head_filled;
    id_pc       = head_filled ? ent_pc[rd_ptr]    : 32'h0;
    id_instr    = head_filled ? ent_instr[rd_ptr] : NOP_INSN;
    id_fault    = head_filled && ent_fault[rd_ptr];
    pop         = head_filled && id_ready;
  end

  // Pointer, occupancy and drop accounting; a redirect flushes everything and
  // turns every still-pending fetch into a future drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pend     <= '0;
      drop_cnt <= '0;
    end else if (pc_src) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
      pend   <= '0;
      if (imem_rsp_valid && ((drop_cnt != '0) || (pend != '0)))
        drop_cnt <= drop_cnt + pend - CNT_W'(1);
      else
        drop_cnt <= drop_cnt + pend;
    end else begin
      if (accept) wr_ptr <= ptr_add(wr_ptr, 1);
      if (pop)    rd_ptr <= ptr_add(rd_ptr, 1);
      count    <= count + CNT_W'(accept) - CNT_W'(pop);
      pend     <= pend + CNT_W'(req_fire) - CNT_W'(rsp_fill && fill_found);
      drop_cnt <= drop_cnt - CNT_W'(rsp_drop);
    end
  end

  // Entry writes: allocation at the tail, response data into the oldest hole.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_filled <= '0;
      ent_fault  <= '0;
    end else if (!pc_src) begin
      if (accept) begin
        ent_pc[wr_ptr]     <= pc;
        ent_instr[wr_ptr]  <= NOP_INSN;
        ent_filled[wr_ptr] <= fault_alloc;
        ent_fault[wr_ptr]  <= fault_alloc;
      end
      if (rsp_fill && fill_found) begin
        ent_instr[fill_idx]  <= imem_rsp_data;
        ent_filled[fill_idx] <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // A response with nothing to drop and nothing pending has no owner.
  always_ff @(posedge clk) begin
    if (!rst && rsp_err)
      $error("if_fetch_queue: unexpected imem response %h", imem_rsp_data);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Purpose  : Directed self-checking bench for if_fetch_queue with a simple
//            pc_unit model and a fixed-latency instruction memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_src;
  logic [31:0] target;
  logic        fetch_stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_fault;

  int tests;
  int failed;
  int cyc;
  int lat;
  int fire_cnt;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t mq[$];

  if_fetch_queue #(.DEPTH(4), .NOP_INSN(32'h0000_0013)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_src         (pc_src),
    .fetch_stall    (fetch_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_fault       (id_fault)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then advance pc_unit and memory.
  task automatic tick();
    logic        fire;
    logic [31:0] addr;
    logic        stall;
    logic        src;
    logic        rst_s;
    @(negedge clk);
    fire  = imem_req_valid && imem_req_ready;
    addr  = imem_req_addr;
    stall = fetch_stall;
    src   = pc_src;
    rst_s = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_s) begin
      pc = 32'h0;
      mq.delete();
    end else begin
      if (fire) begin
        mq.push_back('{addr: addr, due: cyc - 1 + lat});
        fire_cnt++;
      end
      if (src)         pc = target;
      else if (!stall) pc = pc + 32'd4;
    end
    if (!rst_s && mq.size() > 0 && mq[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].addr ^ 32'hA5A5_0000;
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
  endtask

  // Hold reset for two clocks with the given memory latency; caller releases.
  task automatic do_reset(input int l);
    rst    = 1'b1;
    pc_src = 1'b0;
    lat    = l;
    tick();
    tick();
    fire_cnt = 0;
  endtask

  initial begin
    tests          = 0;
    failed         = 0;
    cyc            = 0;
    fire_cnt       = 0;
    lat            = 1;
    rst            = 1'b1;
    pc             = 32'h0;
    pc_src         = 1'b0;
    target         = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    id_ready       = 1'b1;

    // Reset state
    do_reset(1);
    check("rst_id_valid",  {31'h0, id_valid},       32'h0);
    check("rst_id_pc",     id_pc,                   32'h0);
    check("rst_id_instr",  id_instr,                32'h13);
    check("rst_id_fault",  {31'h0, id_fault},       32'h0);
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_stall",     {31'h0, fetch_stall},    32'h1);

    // 1: streaming with 1-cycle memory
    rst = 1'b0;
    #1;
    check("t1_req_valid_c0", {31'h0, imem_req_valid}, 32'h1);
    check("t1_stall_c0",     {31'h0, fetch_stall},    32'h0);
    tick();
    check("t1_id_valid_c1",  {31'h0, id_valid},       32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_id_valid", {31'h0, id_valid},    32'h1);
      check("t1_id_pc",    id_pc,                32'(4 * k));
      check("t1_id_instr", id_instr,             32'(4 * k) ^ 32'hA5A5_0000);
      check("t1_stall",    {31'h0, fetch_stall}, 32'h0);
    end

    // 2: decode stall fills the queue, then drains in order
    do_reset(1);
    id_ready = 1'b0;
    rst      = 1'b0;
    repeat (10) tick();
    check("t2_fires",     32'(fire_cnt),            32'd4);
    check("t2_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("t2_stall",     {31'h0, fetch_stall},    32'h1);
    check("t2_id_valid",  {31'h0, id_valid},       32'h1);
    check("t2_id_pc",     id_pc,                   32'h0);
    check("t2_id_instr",  id_instr,                32'hA5A5_0000);
    id_ready = 1'b1;
    #1;
    check("t2_drain_pc0", id_pc, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t2_drain_valid", {31'h0, id_valid}, 32'h1);
      check("t2_drain_pc",    id_pc,             32'(4 * k));
    end
    check("t2_resumed_fires", 32'(fire_cnt), 32'd7);

    // 3: redirect with two requests in flight, latency 3
    do_reset(3);
    rst = 1'b0;
    tick();
    tick();
    pc_src = 1'b1;
    target = 32'h100;
    #1;
    check("t3_req_valid_redir", {31'h0, imem_req_valid}, 32'h0);
    check("t3_stall_redir",     {31'h0, fetch_stall},    32'h0);
    tick();
    pc_src = 1'b0;
    #1;
    check("t3_count_c3",    32'(dut.count),    32'd0);
    check("t3_drop_c3",     32'(dut.drop_cnt), 32'd2);
    check("t3_id_valid_c3", {31'h0, id_valid}, 32'h0);
    tick();
    check("t3_drop_c4",     32'(dut.drop_cnt), 32'd1);
    check("t3_id_valid_c4", {31'h0, id_valid}, 32'h0);
    tick();
    check("t3_drop_c5",     32'(dut.drop_cnt), 32'd0);
    check("t3_id_valid_c5", {31'h0, id_valid}, 32'h0);
    tick();
    check("t3_id_valid_c6", {31'h0, id_valid}, 32'h0);
    tick();
    check("t3_id_valid_c7", {31'h0, id_valid}, 32'h1);
    check("t3_id_pc_c7",    id_pc,             32'h100);
    check("t3_id_instr_c7", id_instr,          32'hA5A5_0100);

    // 4: redirect coinciding with a response that consumes the pending drop
    do_reset(3);
    rst = 1'b0;
    tick();
    pc_src = 1'b1;
    target = 32'h200;
    tick();
    pc_src = 1'b0;
    #1;
    check("t4_drop_c2", 32'(dut.drop_cnt), 32'd1);
    tick();
    check("t4_pend_c3", 32'(dut.pend), 32'd1);
    pc_src = 1'b1;
    target = 32'h300;
    tick();
    pc_src = 1'b0;
    #1;
    check("t4_drop_c4",     32'(dut.drop_cnt), 32'd1);
    check("t4_count_c4",    32'(dut.count),    32'd0);
    check("t4_id_valid_c4", {31'h0, id_valid}, 32'h0);
    tick();
    check("t4_id_valid_c5", {31'h0, id_valid}, 32'h0);
    tick();
    check("t4_drop_c6",     32'(dut.drop_cnt), 32'd0);
    check("t4_id_valid_c6", {31'h0, id_valid}, 32'h0);
    tick();
    check("t4_id_valid_c7", {31'h0, id_valid}, 32'h0);
    tick();
    check("t4_id_valid_c8", {31'h0, id_valid}, 32'h1);
    check("t4_id_pc_c8",    id_pc,             32'h300);
    check("t4_id_instr_c8", id_instr,          32'hA5A5_0300);

    // 5: misaligned target produces a fault entry without a memory request
    do_reset(1);
    rst    = 1'b0;
    pc_src = 1'b1;
    target = 32'h102;
    tick();
    pc_src = 1'b0;
    #1;
    check("t5_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("t5_stall",     {31'h0, fetch_stall},    32'h0);
    check("t5_id_valid0", {31'h0, id_valid},       32'h0);
    tick();
    check("t5_id_valid",  {31'h0, id_valid},       32'h1);
    check("t5_id_pc",     id_pc,                   32'h102);
    check("t5_id_fault",  {31'h0, id_fault},       32'h1);
    check("t5_id_instr",  id_instr,                32'h13);
    check("t5_fires",     32'(fire_cnt),           32'd0);

    // 6: reset mid-operation
    do_reset(1);
    id_ready = 1'b0;
    rst      = 1'b0;
    tick();
    tick();
    tick();
    check("t6_count_before", 32'(dut.count), 32'd3);
    rst = 1'b1;
    #1;
    check("t6_req_valid_rst", {31'h0, imem_req_valid}, 32'h0);
    tick();
    check("t6_id_valid",   {31'h0, id_valid},       32'h0);
    check("t6_req_valid",  {31'h0, imem_req_valid}, 32'h0);
    check("t6_count",      32'(dut.count),          32'd0);
    check("t6_drop",       32'(dut.drop_cnt),       32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
